// File: rtl/dft_twiddle_seq_if.sv
// Beat stream from the DFT twiddle sequencer to the MAC datapath.
// The master drives the beat fields and valid; the slave returns ready.
interface dft_twiddle_seq_if #(
  parameter int AW = 6
) ();
  logic          out_valid_o;
  logic          out_ready_i;
  logic [AW-1:0] x_addr_o;
  logic [AW-1:0] tw_addr_o;
  logic [AW-1:0] k_o;
  logic          first_o;
  logic          last_o;
  logic          job_last_o;

  modport master (
    output out_valid_o, x_addr_o, tw_addr_o, k_o, first_o, last_o, job_last_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, x_addr_o, tw_addr_o, k_o, first_o, last_o, job_last_o,
    output out_ready_i
  );
endinterface

// File: rtl/dft_twiddle_seq.sv
// Sequencer for an N-point DFT: for each bin k in [k_first, k_last] it issues
// N beats of (n, (k*n) mod N), with the twiddle index built by modular accumulation.
module dft_twiddle_seq #(
  parameter int N  = 64,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [AW-1:0] k_first_i,
  input  logic [AW-1:0] k_last_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          cfg_err_o,
  output logic          aborted_o,
  dft_twiddle_seq_if.master st
);

  localparam logic [AW-1:0] N_M1 = AW'(N - 1);
  localparam logic [AW:0]   N_W  = (AW + 1)'(N);

  typedef enum logic {IDLE, RUN} state_t;

  // tw and k are both below N, so one conditional subtract keeps the sum in range.
  function automatic logic [AW-1:0] tw_step(input logic [AW-1:0] tw, input logic [AW-1:0] k);
    logic [AW:0] sum;
    sum = {1'b0, tw} + {1'b0, k};
    if (sum >= N_W) sum = sum - N_W;
    return sum[AW-1:0];
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] n_q, n_d, k_q, k_d, tw_q, tw_d, klast_q, klast_d;
  logic          valid_q, valid_d, busy_q, busy_d;
  logic          done_q, done_d, cfg_err_q, cfg_err_d, aborted_q, aborted_d;
  logic          first_q, first_d, last_q, last_d, job_last_q, job_last_d;
  logic          xfer, bad_range;

  assign xfer      = valid_q && st.out_ready_i;
  assign bad_range = (k_first_i > k_last_i) || ({1'b0, k_last_i} >= N_W);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    tw_d      = tw_q;
    klast_d   = klast_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        n_d     = '0;
        k_d     = '0;
        tw_d    = '0;
        if (start_i) begin
          if (bad_range) begin
            done_d    = 1'b1;
            cfg_err_d = 1'b1;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            k_d     = k_first_i;
            klast_d = k_last_i;
          end
        end
      end
      RUN: begin
        // Abort wins even over the final transfer of the job.
        if (abort_i) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          n_d       = '0;
          k_d       = '0;
          tw_d      = '0;
        end else if (xfer) begin
          if (n_q != N_M1) begin
            n_d  = n_q + AW'(1);
            tw_d = tw_step(tw_q, k_q);
          end else if (k_q != klast_q) begin
            n_d  = '0;
            tw_d = '0;
            k_d  = k_q + AW'(1);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            n_d     = '0;
            k_d     = '0;
            tw_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    first_d    = valid_d && (n_d == '0);
    last_d     = valid_d && (n_d == N_M1);
    job_last_d = last_d && (k_d == klast_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      k_q        <= '0;
      tw_q       <= '0;
      klast_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      aborted_q  <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      job_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      tw_q       <= tw_d;
      klast_q    <= klast_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      aborted_q  <= aborted_d;
      first_q    <= first_d;
      last_q     <= last_d;
      job_last_q <= job_last_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign cfg_err_o      = cfg_err_q;
  assign aborted_o      = aborted_q;
  assign st.out_valid_o = valid_q;
  assign st.x_addr_o    = n_q;
  assign st.tw_addr_o   = tw_q;
  assign st.k_o         = k_q;
  assign st.first_o     = first_q;
  assign st.last_o      = last_q;
  assign st.job_last_o  = job_last_q;

endmodule

// File: tb/tb_dft_twiddle_seq.sv
// Directed bench for dft_twiddle_seq: N=8 vector table plus hand sequences on
// N=8, N=10 and N=64 (AW=7 so an out-of-range k_last is encodable) instances.
module tb_dft_twiddle_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst64_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=8 instance
  logic       start8 = 0, abort8 = 0, busy8, done8, err8, abt8;
  logic [2:0] kf8 = 0, kl8 = 0;
  dft_twiddle_seq_if #(.AW(3)) if8 ();
  dft_twiddle_seq #(.N(8), .AW(3)) d8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .abort_i(abort8),
    .k_first_i(kf8), .k_last_i(kl8), .busy_o(busy8), .done_o(done8),
    .cfg_err_o(err8), .aborted_o(abt8), .st(if8));

  // N=10 instance
  logic       start10 = 0, abort10 = 0, busy10, done10, err10, abt10;
  logic [3:0] kf10 = 0, kl10 = 0;
  dft_twiddle_seq_if #(.AW(4)) if10 ();
  dft_twiddle_seq #(.N(10), .AW(4)) d10 (
    .clk(clk), .rst_n(rst_n), .start_i(start10), .abort_i(abort10),
    .k_first_i(kf10), .k_last_i(kl10), .busy_o(busy10), .done_o(done10),
    .cfg_err_o(err10), .aborted_o(abt10), .st(if10));

  // N=64 instance, with its own reset
  logic       start64 = 0, abort64 = 0, busy64, done64, err64, abt64;
  logic [6:0] kf64 = 0, kl64 = 0;
  dft_twiddle_seq_if #(.AW(7)) if64 ();
  dft_twiddle_seq #(.N(64), .AW(7)) d64 (
    .clk(clk), .rst_n(rst64_n), .start_i(start64), .abort_i(abort64),
    .k_first_i(kf64), .k_last_i(kl64), .busy_o(busy64), .done_o(done64),
    .cfg_err_o(err64), .aborted_o(abt64), .st(if64));

  typedef struct packed {
    logic [2:0]  kf;
    logic [2:0]  kl;
    logic        err;
    logic        poke;
    logic [15:0] pat;
    logic [63:0] tw;
  } vec_t;
  localparam int NV = 6;
  vec_t vt [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_beat8(input int beat, input int nb, input logic [2:0] tw_e, input int k_e);
    chk("valid8", 32'(if8.out_valid_o), 1);
    chk("busy8", 32'(busy8), 1);
    chk("x8", 32'(if8.x_addr_o), beat % 8);
    chk("tw8", 32'(if8.tw_addr_o), 32'(tw_e));
    chk("k8", 32'(if8.k_o), k_e);
    chk("first8", 32'(if8.first_o), int'(beat % 8 == 0));
    chk("last8", 32'(if8.last_o), int'(beat % 8 == 7));
    chk("joblast8", 32'(if8.job_last_o), int'(beat == nb - 1));
    chk("done8_run", 32'(done8), 0);
  endtask

  task automatic chk_idle64(input string nm);
    chk({nm, "_valid"}, 32'(if64.out_valid_o), 0);
    chk({nm, "_x"}, 32'(if64.x_addr_o), 0);
    chk({nm, "_tw"}, 32'(if64.tw_addr_o), 0);
    chk({nm, "_k"}, 32'(if64.k_o), 0);
    chk({nm, "_first"}, 32'(if64.first_o), 0);
    chk({nm, "_last"}, 32'(if64.last_o), 0);
    chk({nm, "_jl"}, 32'(if64.job_last_o), 0);
    chk({nm, "_busy"}, 32'(busy64), 0);
    chk({nm, "_done"}, 32'(done64), 0);
    chk({nm, "_err"}, 32'(err64), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat, cyc, nb;
    logic rdy;

    // kf, kl, err, poke, ready pattern (bit i = cycle i), tw per beat (nibble i = beat i)
    vt[0] = '{3'd3, 3'd3, 1'b0, 1'b0, 16'hFFFF, 64'h0000_0000_5274_1630};
    vt[1] = '{3'd0, 3'd1, 1'b0, 1'b0, 16'hFFFF, 64'h7654_3210_0000_0000};
    vt[2] = '{3'd5, 3'd5, 1'b0, 1'b0, 16'hCD69, 64'h0000_0000_3614_7250};
    vt[3] = '{3'd7, 3'd7, 1'b0, 1'b1, 16'hFFFF, 64'h0000_0000_1234_5670};
    vt[4] = '{3'd4, 3'd4, 1'b0, 1'b0, 16'hAAAA, 64'h0000_0000_4040_4040};
    vt[5] = '{3'd5, 3'd2, 1'b1, 1'b0, 16'hFFFF, 64'h0};

    if8.out_ready_i = 0;
    if10.out_ready_i = 0;
    if64.out_ready_i = 0;

    // Reset state
    tick();
    chk("rst_valid8", 32'(if8.out_valid_o), 0);
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_x8", 32'(if8.x_addr_o), 0);
    chk_idle64("rst64");
    rst_n = 1;
    rst64_n = 1;
    tick();

    // Table-driven N=8 jobs
    for (int r = 0; r < NV; r++) begin
      nb = (int'(vt[r].kl) - int'(vt[r].kf) + 1) * 8;
      kf8 = vt[r].kf;
      kl8 = vt[r].kl;
      start8 = 1;
      tick();
      start8 = 0;
      if (vt[r].err) begin
        chk("cfg_done8", 32'(done8), 1);
        chk("cfg_err8", 32'(err8), 1);
        chk("cfg_valid8", 32'(if8.out_valid_o), 0);
        chk("cfg_busy8", 32'(busy8), 0);
        tick();
        chk("cfg_done8_end", 32'(done8), 0);
        chk("cfg_valid8_end", 32'(if8.out_valid_o), 0);
        continue;
      end
      beat = 0;
      cyc = 0;
      while (beat < nb && cyc < 200) begin
        chk_beat8(beat, nb, vt[r].tw[4*beat +: 3], int'(vt[r].kf) + beat / 8);
        rdy = (cyc < 16) ? vt[r].pat[cyc] : 1'b1;
        if8.out_ready_i = rdy;
        if (vt[r].poke && cyc == 2) begin
          start8 = 1;
          kf8 = 0;
          kl8 = 0;
        end else begin
          start8 = 0;
        end
        tick();
        if (rdy) beat++;
        cyc++;
      end
      start8 = 0;
      chk("beats8", beat, nb);
      if (vt[r].pat == 16'hFFFF) chk("cycles8", cyc, nb);
      chk("done8", 32'(done8), 1);
      chk("busy8_end", 32'(busy8), 0);
      chk("valid8_end", 32'(if8.out_valid_o), 0);
      chk("err8_end", 32'(err8), 0);
      chk("x8_end", 32'(if8.x_addr_o), 0);
      tick();
      chk("done8_pulse", 32'(done8), 0);
    end

    // abort while idle does nothing
    abort8 = 1;
    tick();
    abort8 = 0;
    chk("idle_abort_aborted8", 32'(abt8), 0);
    chk("idle_abort_busy8", 32'(busy8), 0);

    // start accepted in the done cycle, then abort on the final transfer
    if8.out_ready_i = 1;
    kf8 = 1; kl8 = 1; start8 = 1;
    tick();
    start8 = 0;
    repeat (8) tick();
    chk("b2b_done8", 32'(done8), 1);
    kf8 = 2; kl8 = 2; start8 = 1;
    tick();
    start8 = 0;
    chk("b2b_valid8", 32'(if8.out_valid_o), 1);
    chk("b2b_k8", 32'(if8.k_o), 2);
    chk("b2b_tw8", 32'(if8.tw_addr_o), 0);
    chk("b2b_first8", 32'(if8.first_o), 1);
    chk("b2b_done8_clr", 32'(done8), 0);
    repeat (7) tick();
    chk("b2b_x7", 32'(if8.x_addr_o), 7);
    chk("b2b_tw7", 32'(if8.tw_addr_o), 6);
    chk("b2b_jl7", 32'(if8.job_last_o), 1);
    abort8 = 1;
    tick();
    abort8 = 0;
    chk("abtlast_aborted8", 32'(abt8), 1);
    chk("abtlast_done8", 32'(done8), 0);
    chk("abtlast_valid8", 32'(if8.out_valid_o), 0);
    chk("abtlast_busy8", 32'(busy8), 0);
    tick();
    chk("abtlast_aborted8_pulse", 32'(abt8), 0);
    chk("abtlast_done8_after", 32'(done8), 0);
    if8.out_ready_i = 0;

    // N=10: out-of-range k_last, then a legal non-power-of-two job
    kf10 = 0; kl10 = 12; start10 = 1;
    tick();
    start10 = 0;
    chk("cfg_done10", 32'(done10), 1);
    chk("cfg_err10", 32'(err10), 1);
    chk("cfg_valid10", 32'(if10.out_valid_o), 0);
    tick();
    chk("cfg_done10_end", 32'(done10), 0);
    kf10 = 3; kl10 = 3; start10 = 1; if10.out_ready_i = 1;
    tick();
    start10 = 0;
    for (int n = 0; n < 10; n++) begin
      chk("valid10", 32'(if10.out_valid_o), 1);
      chk("x10", 32'(if10.x_addr_o), n);
      chk("tw10", 32'(if10.tw_addr_o), (3 * n) % 10);
      chk("last10", 32'(if10.last_o), int'(n == 9));
      tick();
    end
    chk("done10", 32'(done10), 1);
    chk("valid10_end", 32'(if10.out_valid_o), 0);
    chk("aborted10", 32'(abt10), 0);

    // N=64: k_last=70 is encodable with AW=7 and must be rejected
    kf64 = 0; kl64 = 7'd70; start64 = 1;
    tick();
    start64 = 0;
    chk("cfg_done64", 32'(done64), 1);
    chk("cfg_err64", 32'(err64), 1);
    chk("cfg_valid64", 32'(if64.out_valid_o), 0);
    tick();

    // full-range job, stalled and aborted mid bin 10
    kf64 = 0; kl64 = 63; start64 = 1; if64.out_ready_i = 1;
    tick();
    start64 = 0;
    repeat (645) tick();
    if64.out_ready_i = 0;
    tick();
    chk("stall64_valid", 32'(if64.out_valid_o), 1);
    chk("stall64_k", 32'(if64.k_o), 10);
    chk("stall64_x", 32'(if64.x_addr_o), 5);
    chk("stall64_tw", 32'(if64.tw_addr_o), 50);
    abort8 = 0;
    abort64 = 1;
    tick();
    abort64 = 0;
    chk("abort64_aborted", 32'(abt64), 1);
    chk_idle64("abort64");

    // restart right away at a different k_first
    kf64 = 4; kl64 = 63; start64 = 1;
    tick();
    start64 = 0;
    chk("restart64_valid", 32'(if64.out_valid_o), 1);
    chk("restart64_x", 32'(if64.x_addr_o), 0);
    chk("restart64_tw", 32'(if64.tw_addr_o), 0);
    chk("restart64_k", 32'(if64.k_o), 4);
    chk("restart64_aborted", 32'(abt64), 0);
    if64.out_ready_i = 1;
    repeat (20) tick();
    chk("beat20_x", 32'(if64.x_addr_o), 20);
    chk("beat20_tw", 32'(if64.tw_addr_o), 16);

    // asynchronous reset mid-job, checked before any clock edge
    #2;
    rst64_n = 0;
    #1;
    chk_idle64("async_rst64");
    chk("async_rst64_aborted", 32'(abt64), 0);
    tick();
    rst64_n = 1;
    tick();
    chk_idle64("post_rst64");
    chk("post_rst64_aborted", 32'(abt64), 0);

    // clean job after reset release
    kf64 = 2; kl64 = 2; start64 = 1;
    tick();
    start64 = 0;
    for (int n = 0; n < 64; n++) begin
      chk("clean64_valid", 32'(if64.out_valid_o), 1);
      chk("clean64_x", 32'(if64.x_addr_o), n);
      chk("clean64_tw", 32'(if64.tw_addr_o), (2 * n) % 64);
      chk("clean64_k", 32'(if64.k_o), 2);
      chk("clean64_first", 32'(if64.first_o), int'(n == 0));
      chk("clean64_jl", 32'(if64.job_last_o), int'(n == 63));
      tick();
    end
    chk("clean64_done", 32'(done64), 1);
    chk("clean64_valid_end", 32'(if64.out_valid_o), 0);
    chk("clean64_busy_end", 32'(busy64), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dft_twiddle_seq.md
Name: dft_twiddle_seq

Overview:
- Sequencer for the N-point DFT datapath. For each output bin k in a requested range, it issues N beats of (sample index n, twiddle index (k*n) mod N).
- The twiddle index addresses the N-entry Q1.15 sin/cos tables, where entry i corresponds to angle 2*pi*i/N.
- It sits between the DFT job controller (start/abort/done) and the MAC datapath (valid/ready stream).

Parameters:
- N, 64, transform length and twiddle table depth; N >= 2, any integer.
- AW, $clog2(N), width of index and bin fields.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start_i  in  1  job request, sampled only when busy_o=0
- abort_i  in  1  cancel the running job
- k_first_i  in  AW  first bin of job, captured on accepted start
- k_last_i  in  AW  last bin of job, captured on accepted start
- busy_o  out  1  job in progress (RUN state)
- done_o  out  1  one-cycle pulse at job end (normal or config error)
- cfg_err_o  out  1  one-cycle pulse with done_o on an illegal range
- aborted_o  out  1  one-cycle pulse when a job is aborted
- out_valid_o  out  1  beat valid
- out_ready_i  in  1  consumer ready
- x_addr_o  out  AW  sample index n
- tw_addr_o  out  AW  twiddle index (k*n) mod N
- k_o  out  AW  current bin k
- first_o  out  1  beat has n=0
- last_o  out  1  beat has n=N-1
- job_last_o  out  1  last beat of job (k=k_last, n=N-1)

Behaviour:
- States are IDLE and RUN. All outputs are registered.
- Reset (rst_n=0):
  - Takes effect immediately and asynchronously; state becomes IDLE.
  - All outputs go to 0; internal n, k and twiddle accumulator are cleared.
  - Applies mid-job too; the partial job is discarded and no done_o/aborted_o pulse is generated.
- Start acceptance:
  - start_i is accepted in a cycle where busy_o=0. This includes the cycle in which done_o is high.
  - start_i is ignored while busy_o=1.
- Illegal range:
  - Condition: k_first_i > k_last_i, or k_last_i >= N.
  - Response: stay IDLE; done_o=1 and cfg_err_o=1 for one cycle at t+1; no beats issued.
- Legal start, accepted at cycle t:
  - At t+1: busy_o=1, out_valid_o=1, n=0, k=k_first, tw=0, first_o=1.
- Transfer occurs when out_valid_o && out_ready_i. On a transfer:
  - If n<N-1: n<=n+1 and tw<=tw+k; if the sum >= N, subtract N. No multiplier; tw+k < 2N fits in AW+1 bits.
  - If n=N-1 and k<k_last: n<=0, tw<=0, k<=k+1.
  - If n=N-1 and k=k_last (job_last_o=1): next cycle out_valid_o=0, busy_o=0, done_o=1 for one cycle, state IDLE.
- Without a transfer (valid=1, ready=0), all beat outputs hold stable.
- Flag derivation:
  - first_o = (n==0)
  - last_o = (n==N-1)
  - job_last_o = last_o && (k==k_last)
- Throughput is one beat per cycle with ready held high. There are no bubbles between bins.
- Abort (abort_i=1 in RUN):
  - Next cycle: out_valid_o=0, busy_o=0, aborted_o=1 for one cycle, state IDLE; done_o is not pulsed.
  - Abort has priority over a simultaneous final transfer: the beat counts as consumed, but only aborted_o pulses.
  - abort_i in IDLE has no effect.
- When out_valid_o=0, the beat fields return to 0.
- Job length is (k_last-k_first+1)*N beats; the minimum cycle count equals the beat count plus 1 for done.

Test Plan:
- N=8, start k_first=k_last=3, ready held 1 -> 8 consecutive beats:
  - x_addr 0..7; tw_addr 0,3,6,1,4,7,2,5.
  - first_o on beat 0; last_o and job_last_o on beat 7.
  - done_o one cycle after beat 7; busy_o high for exactly 8 cycles.
- N=8, k_first=0, k_last=1 -> 16 beats:
  - k=0: tw all 0. k=1: tw 0..7.
  - first_o at beats 0 and 8; last_o at beats 7 and 15; job_last_o only at beat 15; no idle cycle between bins.
- N=8, k=5, ready pattern 1,0,0,1,0,1,1,... -> tw sequence 0,5,2,7,4,1,6,3 is unchanged, and all outputs hold stable during every ready=0 cycle.
- N=64, k_first=0, k_last=63:
  - abort_i asserted with ready=0 mid-bin 10 -> next cycle valid=0 and aborted_o pulse, no done_o.
  - A start one cycle later -> tw=0 and n=0 at k_first.
- Range errors, each giving done_o=cfg_err_o=1 at t+1 and no valid:
  - k_first=5, k_last=2 (N=8).
  - k_last=70 (N=64, AW=6 cannot encode 70).
  - N=10, k_last=12.
- start_i pulsed during RUN -> ignored, sequence unaffected. rst_n low at beat 20 -> all outputs 0 immediately without a clock, no done_o; the first start after release runs a full clean job.
